// File: rtl/alu_addsub_sequencer_if.sv
// Command/result handshake bundle for the nibble-serial add/sub sequencer.
// The master is the operand/command front end; the slave is the sequencer itself.
interface alu_addsub_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, zero, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, zero, busy
    );
endinterface

// File: rtl/alu_addsub_sequencer.sv
// Multi-word add/subtract done one nibble per clock (LSB first) through a single
// 4-bit ripple slice, with the carry held in a register between cycles.
module alu_addsub_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_addsub_sequencer_if.slave bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_next;
    logic             r_op;
    logic             r_carry;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_zero;
    logic [IDXW-1:0]  r_idx;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_sum;
    logic [4:0]       w_c;
    logic             w_last;
    logic             w_accept;
    logic             w_in_ready;
    logic             w_busy;
    logic             w_out_valid;

    // Subtraction is A + ~B + 1: B is inverted per nibble and the +1 enters as the initial carry.
    assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib = r_b[{r_idx, 2'b00} +: 4] ^ {4{r_op}};
    assign w_c[0]  = r_carry;

    for (genvar gi = 0; gi < 4; gi++) begin : g_full_adder
        assign w_sum[gi]  = w_a_nib[gi] ^ w_b_nib[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (w_a_nib[gi] & w_b_nib[gi]) | (w_c[gi] & (w_a_nib[gi] ^ w_b_nib[gi]));
    end

    assign w_last   = (r_idx == IDXW'(NIB - 1));
    assign w_accept = bus.in_valid && w_in_ready;

    always_comb begin
        w_result_next                        = r_result;
        w_result_next[{r_idx, 2'b00} +: 4]   = w_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_next = S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_b;
            r_op    <= bus.in_op;
            r_idx   <= '0;
            r_carry <= bus.in_op;
        end else if (r_state == S_RUN) begin
            r_result <= w_result_next;
            r_carry  <= w_c[4];
            r_idx    <= r_idx + IDXW'(1);
            // Flags are taken from the fully assembled result on the final nibble.
            if (w_last) begin
                r_carry_out <= w_c[4];
                r_overflow  <= (r_a[WIDTH-1] == (r_b[WIDTH-1] ^ r_op)) &&
                               (w_result_next[WIDTH-1] != r_a[WIDTH-1]);
                r_zero      <= (w_result_next == '0);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.carry_out = r_carry_out;
    assign bus.overflow  = r_overflow;
    assign bus.zero      = r_zero;
endmodule

// File: tb/tb_alu_addsub_sequencer.sv
// Scoreboard bench: the driver queues hand-computed results, a negedge monitor
// checks latency and every delivered result against the queue.
module tb_alu_addsub_sequencer;
    localparam int WIDTH = 16;
    localparam int NIB   = 4;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_addsub_sequencer_if #(.WIDTH(WIDTH)) bus();

    alu_addsub_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   ov_prev = 1'b0;
    exp_t exp_q[$];
    int   acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: records accepts, checks first-valid latency and pops on each delivered result.
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
            if (bus.out_valid && !ov_prev) begin
                if (acc_q.size() == 0) check("latency_no_accept", 32'd1, 32'd0);
                else check("latency", 32'(cyc - acc_q.pop_front()), 32'(NIB));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("[TB] result=%h carry=%b ovf=%b zero=%b (expect %h %b %b %b)",
                             bus.result, bus.carry_out, bus.overflow, bus.zero, e.r, e.c, e.o, e.z);
                    check("result",    32'(bus.result),    32'(e.r));
                    check("carry_out", 32'(bus.carry_out), 32'(e.c));
                    check("overflow",  32'(bus.overflow),  32'(e.o));
                    check("zero",      32'(bus.zero),      32'(e.z));
                end
            end
            ov_prev = bus.out_valid;
        end
    end

    // Called and returns in the "posedge + #1" phase.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic op,
                        input logic [15:0] r, input logic c, input logic o, input logic z);
        bit got;
        exp_t e;
        e.r = r; e.c = c; e.o = o; e.z = z;
        exp_q.push_back(e);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!got) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    32'(bus.result),    32'd0);
        check("rst_carry",     32'(bus.carry_out), 32'd0);
        check("rst_overflow",  32'(bus.overflow),  32'd0);
        check("rst_zero",      32'(bus.zero),      32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add, plus RUN-state handshake outputs.
        send(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("run_busy",     32'(bus.busy),     32'd1);
        check("run_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        wait_done();

        // Subtract with borrow, equal operands, signed overflow, full ripple.
        send(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0); wait_done();
        send(16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1); wait_done();
        send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0); wait_done();
        send(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0); wait_done();
        send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1); wait_done();

        // Back-pressure in DONE with a new command pending.
        bus.out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20 && !bus.out_valid; k++) @(negedge clk);
        check("hold_reached_done", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        exp_q.push_back('{r: 16'h1010, c: 1'b0, o: 1'b0, z: 1'b0});
        bus.in_a     = 16'h0F0F;
        bus.in_b     = 16'h0101;
        bus.in_op    = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready",  32'(bus.in_ready),  32'd0);
            check("hold_result",    32'(bus.result),    32'h3333);
            check("hold_busy",      32'(bus.busy),      32'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_done();

        // Asynchronous reset after the second RUN edge.
        send(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy",      32'(bus.busy),      32'd0);
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        check("abort_result",    32'(bus.result),    32'd0);
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        wait_done();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
